spi_slave_16bit: RTL and testbench

- SPI responder (slave) for 16-bit frames, mode 0 (CPOL=0, CPHA=0), MSB first.
- Samples an external master's SCLK/CS/MOSI in the clk domain and drives MISO.
- Delivers each received word with a one-cycle valid pulse, and transmits a word preloaded by local logic.
- Sits at the pin boundary; it is the far end of the team's 16-bit SPI controller, used for loopback and board-to-board links.

---
 rtl/spi_slave_16bit.sv | 205 ++++++++++++++++++++
 tb/tb_spi_slave_16bit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_16bit.sv
// spi_slave_16bit: SPI mode-0 (CPOL=0, CPHA=0) responder for 16-bit MSB-first
// frames. SCLK, CS and MOSI are oversampled in the clk domain; MISO is driven
// from a transmit word preloaded by local logic through tx_data/tx_wr.
module spi_slave_16bit #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] IDLE_WORD   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sclk,
    input  logic        CS,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [15:0] tx_data,
    input  logic        tx_wr,
    output logic        tx_pending,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_d1_q, cs_d1_q;
    logic [SYNC_STAGES:0]   flush_q;
    logic                   armed_q, armed_d;

    logic [15:0] tx_hold_q,  tx_hold_d;
    logic        tx_pending_q, tx_pending_d;
    logic [15:0] tx_shift_q, tx_shift_d;
    logic [15:0] rx_shift_q, rx_shift_d;
    logic [15:0] rx_data_q,  rx_data_d;
    logic [4:0]  bit_cnt_q,  bit_cnt_d;
    logic        complete_q, complete_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        miso_q,     miso_d;
    logic        miso_oe_q,  miso_oe_d;
    logic        busy_q,     busy_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise, frame_start;
    logic [15:0] start_word;

    // Synchronizers plus one edge-detect stage; reset loads idle bus levels.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_d1_q   <= 1'b0;
            cs_d1_q     <= 1'b1;
            flush_q     <= '0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_d1_q   <= sclk_s;
            cs_d1_q     <= cs_s;
            flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
            armed_q     <= armed_d;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    // mosi is taken at the same depth as sclk_s, so it lines up with the detected edge.
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Once the chain holds real pin values, arm only after CS is seen high;
    // this discards a frame that was already running when reset released.
    assign armed_d = armed_q | (flush_q[SYNC_STAGES] & cs_s & cs_d1_q);

    assign sclk_rise   = sclk_s & ~sclk_d1_q;
    assign sclk_fall   = ~sclk_s & sclk_d1_q;
    assign cs_fall     = ~cs_s & cs_d1_q & armed_q;
    assign cs_rise     = cs_s & ~cs_d1_q;
    assign frame_start = (state_q == IDLE) && cs_fall;
    assign start_word  = tx_pending_q ? tx_hold_q : IDLE_WORD;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic; a CS rise on the 16th sclk rise still completes the frame.
    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (cs_fall) state_d = SHIFT;
            SHIFT: begin
                if (sclk_rise && bit_cnt_q == 5'd15) state_d = cs_rise ? IDLE : DONE;
                else if (cs_rise)                    state_d = IDLE;
            end
            DONE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        tx_hold_d    = tx_hold_q;
        tx_pending_d = tx_pending_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        bit_cnt_d    = bit_cnt_q;
        miso_d       = miso_q;
        complete_d   = 1'b0;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;

        // tx_shift keeps the bits still to go out after the one already on miso.
        if (frame_start) begin
            miso_d       = start_word[15];
            tx_shift_d   = {start_word[14:0], 1'b0};
            tx_pending_d = 1'b0;
            bit_cnt_d    = 5'd0;
        end

        if (state_q == SHIFT) begin
            if (sclk_rise && bit_cnt_q == 5'd15) begin
                rx_shift_d = {rx_shift_q[14:0], mosi_s};
                bit_cnt_d  = 5'd16;
                complete_d = 1'b1;
                miso_d     = 1'b0;
            end else if (cs_rise) begin
                frame_err_d = (bit_cnt_q != 5'd0);
                miso_d      = 1'b0;
            end else if (sclk_rise) begin
                rx_shift_d = {rx_shift_q[14:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + 5'd1;
            end else if (sclk_fall && bit_cnt_q != 5'd0) begin
                miso_d     = tx_shift_q[15];
                tx_shift_d = {tx_shift_q[14:0], 1'b0};
            end
        end else if (state_q == DONE) begin
            miso_d = 1'b0;
        end

        // Publish the word one cycle after the last bit lands.
        if (complete_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end

        // A local write wins over the frame-start clear and stays pending.
        if (tx_wr) begin
            tx_hold_d    = tx_data;
            tx_pending_d = 1'b1;
        end

        miso_oe_d = (state_d != IDLE);
        busy_d    = (state_d != IDLE);
    end

    // Datapath registers, all returned to their idle values on reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_hold_q    <= IDLE_WORD;
            tx_pending_q <= 1'b0;
            tx_shift_q   <= IDLE_WORD;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            bit_cnt_q    <= '0;
            complete_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            tx_hold_q    <= tx_hold_d;
            tx_pending_q <= tx_pending_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            bit_cnt_q    <= bit_cnt_d;
            complete_q   <= complete_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            busy_q       <= busy_d;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign tx_pending = tx_pending_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave_16bit.sv
// tb_spi_slave_16bit: directed bench acting as an SPI mode-0 master (SCLK=clk/8).
module tb_spi_slave_16bit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sclk;
    logic        CS;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [15:0] tx_data;
    logic        tx_wr;
    logic        tx_pending;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        frame_err;

    int checks = 0;
    int fails  = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    logic [15:0] last_rx = 16'h0;

    spi_slave_16bit #(.SYNC_STAGES(2), .IDLE_WORD(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .CS(CS), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_pending(tx_pending), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            last_rx   = rx_data;
        end
        if (frame_err === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [15:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic cs_low();
        CS = 1'b0;
        wait_clks(4);
    endtask

    task automatic cs_high();
        wait_clks(4);
        CS = 1'b1;
        wait_clks(8);
    endtask

    // Master shifts nbits; miso is read at each sclk rise (first 16 kept in got).
    task automatic shift_bits(input logic [15:0] word, input int nbits,
                              output logic [15:0] got, output logic extra_miso);
        got = 16'h0;
        extra_miso = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? word[15-i] : 1'b1;
            wait_clks(4);
            if (i < 16) got[15-i] = miso;
            else        extra_miso = extra_miso | miso;
            sclk = 1'b1;
            wait_clks(4);
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        int v0, e0;
        reset_n = 1'b0; sclk = 1'b0; CS = 1'b1; mosi = 1'b0;
        tx_data = 16'h0; tx_wr = 1'b0;
        wait_clks(3);
        checks++; if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b want 0", miso); end
        checks++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rx_data !== 16'h0) begin fails++; $display("FAIL reset_rx_data: got %h want 0000", rx_data); end
        checks++; if (tx_pending !== 1'b0) begin fails++; $display("FAIL reset_tx_pending: got %b want 0", tx_pending); end
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        reset_n = 1'b1;
        v0 = valid_cnt; e0 = err_cnt;
        wait_clks(100);
        checks++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL idle_rx_valid: got %0d pulses want 0", valid_cnt - v0); end
        checks++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL idle_frame_err: got %0d pulses want 0", err_cnt - e0); end
        checks++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL idle_miso_oe: got %b want 0", miso_oe); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic_frame();
        int v0, e0;
        logic [15:0] got;
        logic ex;
        write_tx(16'hA5C3);
        checks++; if (tx_pending !== 1'b1) begin fails++; $display("FAIL basic_pending_set: got %b want 1", tx_pending); end
        v0 = valid_cnt; e0 = err_cnt;
        cs_low();
        checks++; if (tx_pending !== 1'b0) begin fails++; $display("FAIL basic_pending_clear: got %b want 0", tx_pending); end
        checks++; if (miso_oe !== 1'b1) begin fails++; $display("FAIL basic_miso_oe: got %b want 1", miso_oe); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b want 1", busy); end
        shift_bits(16'h1234, 16, got, ex);
        cs_high();
        checks++; if (got !== 16'hA5C3) begin fails++; $display("FAIL basic_miso_word: got %h want a5c3", got); end
        checks++; if (rx_data !== 16'h1234) begin fails++; $display("FAIL basic_rx_data: got %h want 1234", rx_data); end
        checks++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL basic_rx_valid: got %0d pulses want 1", valid_cnt - v0); end
        checks++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL basic_frame_err: got %0d pulses want 0", err_cnt - e0); end
        checks++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin fails++; $display("FAIL basic_end_idle: got busy=%b oe=%b want 0 0", busy, miso_oe); end
    endtask

    task automatic test_back_to_back();
        int v0;
        logic [15:0] got1, got2;
        logic ex;
        write_tx(16'h3C96);
        v0 = valid_cnt;
        cs_low();
        shift_bits(16'hFFFF, 16, got1, ex);
        cs_high();
        checks++; if (last_rx !== 16'hFFFF) begin fails++; $display("FAIL b2b_rx1: got %h want ffff", last_rx); end
        cs_low();
        shift_bits(16'h0001, 16, got2, ex);
        cs_high();
        checks++; if (got1 !== 16'h3C96) begin fails++; $display("FAIL b2b_miso1: got %h want 3c96", got1); end
        checks++; if (got2 !== 16'h0000) begin fails++; $display("FAIL b2b_miso2_idle_word: got %h want 0000", got2); end
        checks++; if (valid_cnt - v0 !== 2) begin fails++; $display("FAIL b2b_rx_valid: got %0d pulses want 2", valid_cnt - v0); end
        checks++; if (rx_data !== 16'h0001) begin fails++; $display("FAIL b2b_rx_data: got %h want 0001", rx_data); end
    endtask

    task automatic test_frame_error();
        int v0, e0;
        logic [15:0] got;
        logic ex;
        v0 = valid_cnt; e0 = err_cnt;
        cs_low();
        shift_bits(16'hBEEF, 7, got, ex);
        cs_high();
        checks++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL ferr_pulse: got %0d pulses want 1", err_cnt - e0); end
        checks++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL ferr_rx_valid: got %0d pulses want 0", valid_cnt - v0); end
        checks++; if (rx_data !== 16'h0001) begin fails++; $display("FAIL ferr_rx_data_kept: got %h want 0001", rx_data); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_busy: got %b want 0", busy); end
    endtask

    task automatic test_extra_edges();
        int v0, e0;
        logic [15:0] got;
        logic ex;
        v0 = valid_cnt; e0 = err_cnt;
        cs_low();
        shift_bits(16'hC0DE, 18, got, ex);
        checks++; if (miso !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL extra_done_state: got miso=%b busy=%b want 0 1", miso, busy); end
        cs_high();
        checks++; if (ex !== 1'b0) begin fails++; $display("FAIL extra_miso_done: got %b want 0", ex); end
        checks++; if (rx_data !== 16'hC0DE) begin fails++; $display("FAIL extra_rx_data: got %h want c0de", rx_data); end
        checks++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL extra_rx_valid: got %0d pulses want 1", valid_cnt - v0); end
        checks++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL extra_frame_err: got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_same_cycle_write();
        logic [15:0] got;
        logic ex;
        write_tx(16'h1111);
        // CS falls at a negedge; the fall is acted on at the third rising edge after it.
        CS = 1'b0;
        wait_clks(2);
        tx_data = 16'h5555;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
        wait_clks(2);
        checks++; if (tx_pending !== 1'b1) begin fails++; $display("FAIL same_pending_kept: got %b want 1", tx_pending); end
        shift_bits(16'h0F0F, 16, got, ex);
        cs_high();
        checks++; if (got !== 16'h1111) begin fails++; $display("FAIL same_old_word: got %h want 1111", got); end
        checks++; if (tx_pending !== 1'b1) begin fails++; $display("FAIL same_pending_after: got %b want 1", tx_pending); end
        cs_low();
        shift_bits(16'h0F0F, 16, got, ex);
        cs_high();
        checks++; if (got !== 16'h5555) begin fails++; $display("FAIL same_new_word: got %h want 5555", got); end
        checks++; if (tx_pending !== 1'b0) begin fails++; $display("FAIL same_pending_clear: got %b want 0", tx_pending); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0;
        logic [15:0] got;
        logic ex;
        v0 = valid_cnt; e0 = err_cnt;
        cs_low();
        shift_bits(16'hDEAD, 9, got, ex);
        write_tx(16'h7777);
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (miso_oe !== 1'b0 || busy !== 1'b0 || miso !== 1'b0) begin fails++; $display("FAIL midrst_outputs: got oe=%b busy=%b miso=%b want 0 0 0", miso_oe, busy, miso); end
        checks++; if (rx_data !== 16'h0 || tx_pending !== 1'b0) begin fails++; $display("FAIL midrst_regs: got rx=%h pend=%b want 0000 0", rx_data, tx_pending); end
        wait_clks(2);
        reset_n = 1'b1;
        // The master finishes its frame unaware; the slave must ignore it.
        shift_bits(16'h00AD, 7, got, ex);
        cs_high();
        checks++; if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin fails++; $display("FAIL midrst_pulses: got valid=%0d err=%0d want 0 0", valid_cnt - v0, err_cnt - e0); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
        cs_low();
        shift_bits(16'h2468, 16, got, ex);
        cs_high();
        checks++; if (rx_data !== 16'h2468) begin fails++; $display("FAIL midrst_recover_rx: got %h want 2468", rx_data); end
        checks++; if (got !== 16'h0000) begin fails++; $display("FAIL midrst_recover_miso: got %h want 0000", got); end
        checks++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL midrst_recover_valid: got %0d pulses want 1", valid_cnt - v0); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_frame_error();
        test_extra_edges();
        test_same_cycle_write();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
